// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage of the pipelined MIPS CPU.
// Owns the PC, issues instruction memory requests over a req/ready
// handshake, and holds one fetched instruction for the IF/ID register.
//
// Handshake: oIMemReq/oIMemAddr are held stable until a cycle in which
// iIMemReady=1. That cycle completes the transfer and iIMemData is
// sampled in that same cycle. Downstream consumes the buffer in any cycle
// with IF_ID_Write=1.
//
// Optional feature macro: IF_FETCH_STALL_CNT_EN adds the oStallCnt output,
// which counts cycles with oValid=1 and IF_ID_Write=0.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_ID_Write,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemReady,
  input  logic [31:0] iIMemData,
  output logic        oValid,
  output logic [31:0] oInstruction,
  output logic [31:0] oNextPC
`ifdef IF_FETCH_STALL_CNT_EN
  ,
  output logic [31:0] oStallCnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_nextpc;

  logic        issue;
  logic [31:0] addr_inc;

  // Idle issues only when the buffer is empty or being drained this cycle.
  // Once a request is outstanding it stays asserted until answered.
  assign issue     = (state == S_IDLE) ? (~buf_valid | IF_ID_Write) : 1'b1;
  assign oIMemReq  = ~reset & issue;
  assign oIMemAddr = (state == S_IDLE) ? pc : req_addr;
  assign addr_inc  = oIMemAddr + 32'd4;

  assign oValid       = buf_valid;
  assign oInstruction = buf_instr;
  assign oNextPC      = buf_nextpc;

  // Fetch FSM, PC and one-entry instruction buffer. A redirect overrides
  // everything and turns any unanswered request into one to be dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      buf_valid  <= 1'b0;
      buf_instr  <= 32'h0;
      buf_nextpc <= RESET_PC;
    end else begin
      // Downstream took the buffer; refill below may override this.
      if (IF_ID_Write) begin
        buf_valid <= 1'b0;
        buf_instr <= 32'h0;
      end
      if (iRedirect) begin
        pc        <= iRedirectPC & 32'hFFFF_FFFC;
        buf_valid <= 1'b0;
        buf_instr <= 32'h0;
        if (oIMemReq && !iIMemReady) begin
          req_addr <= oIMemAddr;
          state    <= S_DROP;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE, S_WAIT: begin
            if (oIMemReq) begin
              if (iIMemReady) begin
                buf_valid  <= 1'b1;
                buf_instr  <= iIMemData;
                buf_nextpc <= addr_inc;
                pc         <= addr_inc;
                state      <= S_IDLE;
              end else begin
                req_addr <= oIMemAddr;
                state    <= S_WAIT;
              end
            end
          end
          S_DROP: begin
            if (iIMemReady) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef IF_FETCH_STALL_CNT_EN
  // Counts cycles where a valid instruction is held by a downstream stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      oStallCnt <= 32'h0;
    end else if (buf_valid && !IF_ID_Write) begin
      oStallCnt <= oStallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven cycle vectors plus hand-written redirect
// sequences for if_fetch_unit. The memory model returns addr + 0x10000000
// with a configurable number of wait cycles.
module tb_if_fetch_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        IF_ID_Write;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oIMemReq;
  logic [31:0] oIMemAddr;
  logic        iIMemReady;
  logic [31:0] iIMemData;
  logic        oValid;
  logic [31:0] oInstruction;
  logic [31:0] oNextPC;
`ifdef IF_FETCH_STALL_CNT_EN
  logic [31:0] oStallCnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h80000000)) dut (
    .clk(clk),
    .reset(reset),
    .IF_ID_Write(IF_ID_Write),
    .iRedirect(iRedirect),
    .iRedirectPC(iRedirectPC),
    .oIMemReq(oIMemReq),
    .oIMemAddr(oIMemAddr),
    .iIMemReady(iIMemReady),
    .iIMemData(iIMemData),
    .oValid(oValid),
    .oInstruction(oInstruction),
    .oNextPC(oNextPC)
`ifdef IF_FETCH_STALL_CNT_EN
    ,
    .oStallCnt(oStallCnt)
`endif
  );

  // ---------------- memory model ----------------
  // Ready is asserted after mem_lat unanswered request cycles.
  int mem_lat = 0;
  int mem_cnt = 0;

  initial begin
    iIMemReady = 1'b0;
    iIMemData  = 32'h0;
  end

  always @(negedge clk) begin
    #1;
    iIMemData = oIMemAddr + 32'h10000000;
    if (reset || !oIMemReq) begin
      iIMemReady = 1'b0;
      mem_cnt    = 0;
    end else begin
      iIMemReady = (mem_cnt >= mem_lat);
      mem_cnt    = iIMemReady ? 0 : mem_cnt + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the falling edge, then waits until the
  // memory model has responded so outputs can be sampled mid-cycle.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [31:0] rpc, input int lat);
    @(negedge clk);
    reset       = rst;
    IF_ID_Write = wr;
    iRedirect   = rd;
    iRedirectPC = rpc;
    mem_lat     = lat;
    #2;
  endtask

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [31:0] rpc;
    int          lat;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] nextpc;
    logic [31:0] sc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset       = 1'b1;
    IF_ID_Write = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPC = 32'h0;

    //               rst wr rd rpc           lat req addr          v  instr         nextpc        stallcnt
    vecs.push_back('{1, 0, 0, 32'h0,        0, 0, 32'h80000000, 0, 32'h0,        32'h80000000, 0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80000000, 0, 32'h0,        32'h80000000, 0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80000004, 1, 32'h90000000, 32'h80000004, 0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80000008, 1, 32'h90000004, 32'h80000008, 0});
    vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h8000000C, 1, 32'h90000008, 32'h8000000C, 0});
    vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h8000000C, 1, 32'h90000008, 32'h8000000C, 1});
    vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h8000000C, 1, 32'h90000008, 32'h8000000C, 2});
    vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 32'h8000000C, 1, 32'h90000008, 32'h8000000C, 3});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h8000000C, 1, 32'h90000008, 32'h8000000C, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h80000010, 1, 32'h9000000C, 32'h80000010, 4});
    vecs.push_back('{0, 1, 1, 32'h80001002, 2, 1, 32'h80000010, 0, 32'h0,        32'h80000010, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h80000010, 0, 32'h0,        32'h80000010, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h80001000, 0, 32'h0,        32'h80000010, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h80001000, 0, 32'h0,        32'h80000010, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h80001000, 0, 32'h0,        32'h80000010, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80001004, 1, 32'h90001000, 32'h80001004, 4});
    vecs.push_back('{0, 1, 1, 32'hFFFFFFFC, 0, 1, 32'h80001008, 1, 32'h90001004, 32'h80001008, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'h80001008, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h00000000, 1, 32'h0FFFFFFC, 32'h00000000, 4});
    vecs.push_back('{0, 1, 0, 32'h0,        2, 1, 32'h00000004, 1, 32'h10000000, 32'h00000004, 4});
    vecs.push_back('{1, 1, 0, 32'h0,        2, 0, 32'h00000004, 0, 32'h0,        32'h00000004, 4});
    vecs.push_back('{1, 1, 0, 32'h0,        0, 0, 32'h80000000, 0, 32'h0,        32'h80000000, 0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80000000, 0, 32'h0,        32'h80000000, 0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 32'h80000004, 1, 32'h90000000, 32'h80000004, 0});

    // Bring the design out of an unknown state before the table starts.
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].rpc, vecs[i].lat);
      check($sformatf("row%0d req", i),    {31'h0, oIMemReq}, {31'h0, vecs[i].req});
      check($sformatf("row%0d addr", i),   oIMemAddr,         vecs[i].addr);
      check($sformatf("row%0d valid", i),  {31'h0, oValid},   {31'h0, vecs[i].valid});
      check($sformatf("row%0d instr", i),  oInstruction,      vecs[i].instr);
      check($sformatf("row%0d nextpc", i), oNextPC,           vecs[i].nextpc);
`ifdef IF_FETCH_STALL_CNT_EN
      check($sformatf("row%0d stallcnt", i), oStallCnt, vecs[i].sc);
`endif
    end

    // Redirect while waiting, then a second redirect while dropping:
    // the last target wins and is fetched after the dropped response.
    step(0, 1, 0, 32'h0, 3);
    check("seq_a addr", oIMemAddr, 32'h80000008);
    step(0, 1, 1, 32'h80002000, 3);
    check("seq_b req", {31'h0, oIMemReq}, 32'h1);
    check("seq_b valid", {31'h0, oValid}, 32'h0);
    step(0, 1, 1, 32'h80003004, 3);
    check("seq_c addr held", oIMemAddr, 32'h80000008);
    step(0, 1, 0, 32'h0, 3);
    check("seq_d addr held", oIMemAddr, 32'h80000008);
    check("seq_d req", {31'h0, oIMemReq}, 32'h1);
    step(0, 1, 0, 32'h0, 0);
    check("seq_e addr", oIMemAddr, 32'h80003004);
    check("seq_e valid", {31'h0, oValid}, 32'h0);

    // Redirect during a stall: buffer dropped, target fetched next cycle.
    step(0, 0, 1, 32'h00000103, 0);
    check("seq_f req", {31'h0, oIMemReq}, 32'h0);
    check("seq_f valid", {31'h0, oValid}, 32'h1);
    check("seq_f instr", oInstruction, 32'h90003004);
    check("seq_f nextpc", oNextPC, 32'h80003008);
    step(0, 1, 0, 32'h0, 0);
    check("seq_g req", {31'h0, oIMemReq}, 32'h1);
    check("seq_g addr", oIMemAddr, 32'h00000100);
    check("seq_g valid", {31'h0, oValid}, 32'h0);
    check("seq_g instr", oInstruction, 32'h0);
`ifdef IF_FETCH_STALL_CNT_EN
    check("seq_g stallcnt", oStallCnt, 32'h1);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
